// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states,
// load extension modes and the request legality check.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_e;

  localparam int unsigned CNT_W = 8;

  // True when the access is misaligned for its size, or is a doubleword
  // on a 32-bit datapath.
  function automatic logic req_illegal(input size_e size, input logic [2:0] lo,
                                       input logic wide);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo[1:0];
      default: bad = !wide || (|lo);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the load/store unit: byte enables, store data
// replication and load data alignment with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  size_e                     size,
  input  ext_e                      ext,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN/8-1:0]         byte_en,
  output logic [XLEN-1:0]           wdata_rep,
  output logic [XLEN-1:0]           load_data
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned MW = $clog2(XLEN);

  logic [NB-1:0]   mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic [7:0]      nbits;
  logic [MW-1:0]   msb;
  logic            sbit;

  // Byte-enable mask for the access size and store data replicated across all lanes.
  always_comb begin
    mask      = '0;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        mask[0]   = 1'b1;
        wdata_rep = {NB{wdata[7:0]}};
      end
      SZ_HALF: begin
        mask[1:0] = '1;
        wdata_rep = {(NB/2){wdata[15:0]}};
      end
      SZ_WORD: begin
        mask[3:0] = '1;
        wdata_rep = {(NB/4){wdata[31:0]}};
      end
      default: begin
        mask      = '1;
        wdata_rep = wdata;
      end
    endcase
    byte_en = mask << lane;
  end

  // Shift the addressed lanes down to bit 0 and extend above the access width.
  always_comb begin
    shifted   = rdata >> {lane, 3'b000};
    nbits     = 8'd8 << size;
    keep      = ~({XLEN{1'b1}} << nbits);
    msb       = MW'(nbits - 8'd1);
    sbit      = (ext == EXT_SIGN) && shifted[msb];
    load_data = (shifted & keep) | ({XLEN{sbit}} & ~keep);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, performs one
// memory access with a bounded wait for ack, and returns one response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_read_wrn,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_byte_en,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ack,
  output logic                rsp_valid,
  output logic [4:0]          rsp_rd,
  output logic [XLEN-1:0]     rsp_data,
  output logic                rsp_error,
  output logic                busy
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(NB - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               accept, capture, bad;
  logic               store_q;
  size_e              size_q;
  ext_e               ext_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [XLEN-1:0]    wdata_q, rdata_q;
  logic [4:0]         rd_q;
  logic               in_access, in_resp, wr_ok;
  logic [NB-1:0]      be;
  logic [XLEN-1:0]    wrep, ldata;

  assign bad = req_illegal(size_e'(req_size), req_addr[2:0], XLEN == 64);

  // State, wait counter and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; halt blocks every transition so state and counter hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    capture = 1'b0;
    if (!halt) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            accept  = 1'b1;
            cnt_d   = '0;
            err_d   = bad;
            state_d = bad ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            capture = 1'b1;
            state_d = ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Request fields latched on acceptance; read data latched on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      size_q  <= SZ_BYTE;
      ext_q   <= EXT_SIGN;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        store_q <= req_store;
        size_q  <= size_e'(req_size);
        ext_q   <= ext_e'(req_unsigned);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .lane      (addr_q[LW-1:0]),
    .size      (size_q),
    .ext       (ext_q),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .byte_en   (be),
    .wdata_rep (wrep),
    .load_data (ldata)
  );

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);
  assign wr_ok     = in_resp && !err_q && !store_q;

  // rst_n gates req_ready so every handshake output reads 0 while reset is held.
  assign req_ready    = rst_n && (state_q == ST_IDLE) && !halt;
  assign busy         = (state_q != ST_IDLE);
  assign mem_req      = in_access;
  assign mem_read_wrn = !(in_access && store_q);
  assign mem_addr     = in_access ? (addr_q & ADDR_MASK) : '0;
  assign mem_byte_en  = in_access ? be : '0;
  assign mem_wdata    = in_access ? wrep : '0;
  assign rsp_valid    = in_resp;
  assign rsp_error    = in_resp && err_q;
  assign rsp_rd       = wr_ok ? rd_q : '0;
  assign rsp_data     = wr_ok ? ldata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (XLEN=32, ADDR_W=16, TIMEOUT=4).
module tb_load_store_unit;

  localparam int TO = 4;
  localparam logic [94:0] RST_EXP = 95'd1 << 91;

  logic        clk = 1'b0;
  logic        rst_n, halt, req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [15:0] req_addr, mem_addr;
  logic [31:0] req_wdata, mem_wdata, mem_rdata, rsp_data;
  logic [4:0]  req_rd, rsp_rd;
  logic        mem_req, mem_read_wrn, mem_ack, rsp_valid, rsp_error, busy;
  logic [3:0]  mem_byte_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_read_wrn(mem_read_wrn), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .busy(busy)
  );

  // Reference model: lanes lo .. lo+n-1 enabled.
  function automatic logic [3:0] m_be(input int n, input int lo);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) if (i >= lo && i < lo + n) r[i] = 1'b1;
    return r;
  endfunction

  // Reference model: byte k of the bus carries store byte (k mod n).
  function automatic logic [31:0] m_rep(input logic [31:0] wd, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  // Reference model: numeric value of the addressed bytes, extended.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input int lo,
                                          input int n, input bit uns);
    longint unsigned v;
    v = (64'(rd) >> (8 * lo)) & ((64'd1 << (8 * n)) - 1);
    if (!uns && ((v >> (8 * n - 1)) & 1) != 0) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [94:0] all_outs();
    return {busy, req_ready, mem_req, mem_read_wrn, mem_addr, mem_byte_en, mem_wdata,
            rsp_valid, rsp_error, rsp_rd, rsp_data};
  endfunction

  task automatic do_txn(input string tag, input bit st, input bit [1:0] sz, input bit uns,
                        input logic [15:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdat, input int dly);
    int n, lo;
    bit bad, err;
    logic [53:0] eb, gb;
    logic [40:0] er, gr;
    logic [31:0] ed;
    n   = 1 << sz;
    lo  = int'(a % 4);
    bad = (sz == 2'd3) || (a % n != 0);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready: got %b exp 1", tag, req_ready);
    end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = $urandom; req_rd = 5'($urandom);
    err = bad;
    if (!bad) begin
      eb = {1'b1, !st, a & 16'hFFFC, m_be(n, lo), m_rep(wd, n)};
      for (int c = 0; c < TO; c++) begin
        gb = {mem_req, mem_read_wrn, mem_addr, mem_byte_en, mem_wdata};
        n_tests++;
        if (gb !== eb) begin
          n_fail++; $display("FAIL %s bus c%0d: got %h exp %h", tag, c, gb, eb);
        end
        mem_rdata = (c == dly) ? rdat : $urandom;
        mem_ack   = (c == dly);
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        if (c == dly) break;
      end
      err = (dly >= TO);
    end
    ed = (err || st) ? 32'd0 : m_load(rdat, lo, n, uns);
    er = {1'b1, err, (err || st) ? 5'd0 : rd, ed, 1'b0, 1'b1};
    gr = {rsp_valid, rsp_error, rsp_rd, rsp_data, mem_req, busy};
    n_tests++;
    if (gr !== er) begin
      n_fail++; $display("FAIL %s rsp: got %h exp %h", tag, gr, er);
    end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++; $display("FAIL %s idle: got %b exp 001", tag, {rsp_valid, busy, req_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (all_outs() !== RST_EXP) begin
      n_fail++; $display("FAIL reset_outs: got %h exp %h", all_outs(), RST_EXP);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_txn("load_half_signed", 1'b0, 2'd1, 1'b0, 16'h0006, 32'h0, 5'd7, 32'h8001_0000, 0);
    do_txn("store_byte", 1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_00AB, 5'd3, 32'h0, 1);
    do_txn("misaligned_word", 1'b0, 2'd2, 1'b0, 16'h0002, 32'h0, 5'd9, 32'h0, 0);
    do_txn("illegal_dword", 1'b0, 2'd3, 1'b0, 16'h0000, 32'h0, 5'd10, 32'h0, 0);
    do_txn("load_byte_unsigned", 1'b0, 2'd0, 1'b1, 16'h0101, 32'h0, 5'd31, 32'h0000_F200, 2);
    do_txn("load_word_last_ack", 1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 5'd1, 32'hCAFE_0001, TO - 1);
  endtask

  task automatic test_timeout();
    do_txn("timeout_load", 1'b0, 2'd2, 1'b1, 16'h0004, 32'h0, 5'd4, 32'h0, 99);
    do_txn("timeout_store", 1'b1, 2'd1, 1'b0, 16'h00FE, 32'h1234, 5'd5, 32'h0, TO);
  endtask

  task automatic test_halt();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 16'h0008; req_rd = 5'd12;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({mem_req, busy, req_ready, rsp_valid} !== 4'b1100) begin
        n_fail++;
        $display("FAIL halt_access%0d: got %b exp 1100", i, {mem_req, busy, req_ready, rsp_valid});
      end
    end
    halt = 1'b0;
    // Counter must resume from zero: TIMEOUT more ACCESS cycles are available.
    for (int c = 0; c < TO; c++) begin
      n_tests++;
      if (mem_req !== 1'b1) begin
        n_fail++; $display("FAIL halt_resume c%0d: got mem_req %b exp 1", c, mem_req);
      end
      mem_ack = (c == TO - 1); mem_rdata = 32'h1234_5678;
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0;
    end
    n_tests++;
    if ({rsp_valid, rsp_error, rsp_rd, rsp_data} !== {2'b10, 5'd12, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL halt_rsp: got %h exp %h", {rsp_valid, rsp_error, rsp_rd, rsp_data},
               {2'b10, 5'd12, 32'h1234_5678});
    end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_single_pulse: got %b exp 0", rsp_valid);
    end
    // Halt while in RESP: response stays visible until halt falls.
    req_valid = 1'b1; req_size = 2'd1; req_addr = 16'h0001; req_rd = 5'd2;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) halt = 1'b0;
      n_tests++;
      if ({rsp_valid, rsp_error} !== 2'b11) begin
        n_fail++; $display("FAIL halt_resp%0d: got %b exp 11", i, {rsp_valid, rsp_error});
      end
      @(posedge clk); @(negedge clk);
    end
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL halt_resp_end: got %b exp 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd1; req_addr = 16'h0002; req_rd = 5'd6;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_access: got mem_req %b exp 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (all_outs() !== RST_EXP) begin
      n_fail++; $display("FAIL rstmid_async: got %h exp %h", all_outs(), RST_EXP);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if ({rsp_valid, mem_req, busy, req_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL rstmid_after%0d: got %b exp 0001", i, {rsp_valid, mem_req, busy, req_ready});
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit [1:0]    sz;
      logic [15:0] a;
      sz = 2'($urandom % 4);
      a  = 16'($urandom);
      if ($urandom % 2 == 0) a = a & ~16'((1 << sz) - 1);
      do_txn("random", 1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom),
             $urandom, int'($urandom % 6));
    end
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_directed();
    test_timeout();
    test_halt();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
